// File: rtl/cpu_mem_arb.sv
// -----------------------------------------------------------------------------
// cpu_mem_arb
//
// Purpose:
//   Merges the CPU instruction port and the CPU data port onto a single
//   pipelined Wishbone master toward unified memory. Only one memory
//   transaction is outstanding at a time. The data port's 2-bit access size
//   is turned into byte selects, and store data is replicated across the
//   byte lanes. Load data is returned as the raw memory word; the CPU does
//   the lane extraction and sign extension itself.
//
// Configuration:
//   CPU_ARB_RR_EN - when defined, arbitration alternates between the ports
//                   whenever both request in the same IDLE cycle. The port
//                   that did not win the last completed transaction wins.
//                   When undefined, the data port always wins, so a stream
//                   of back-to-back data accesses can starve instruction
//                   fetches.
//
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-low reset
//   inst_cyc_in/stb_in      instruction cycle/strobe from CPU
//   inst_addr_in            instruction address
//   inst_ack_out            one-cycle instruction ack
//   inst_data_out           instruction word, valid with inst_ack_out
//   inst_stall_out          instruction strobe not accepted this cycle
//                           (combinational)
//   data_stb_in             data strobe, held by CPU until data_ack_out
//   data_we_in              1 = store
//   data_be_in              access size: 00 byte, 01 half, 1x word
//   data_addr_in            byte address
//   data_data_in            right-aligned store data
//   data_ack_out            one-cycle data ack
//   data_data_out           raw load word, valid with data_ack_out
//   mem_cyc/stb/we/sel/addr/data_out   pipelined Wishbone master outputs
//   mem_ack_in/stall_in/data_in        Wishbone slave responses
// -----------------------------------------------------------------------------
module cpu_mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,

  input  logic              inst_cyc_in,
  input  logic              inst_stb_in,
  input  logic [ADDR_W-1:0] inst_addr_in,
  output logic              inst_ack_out,
  output logic [DATA_W-1:0] inst_data_out,
  output logic              inst_stall_out,

  input  logic              data_stb_in,
  input  logic              data_we_in,
  input  logic [1:0]        data_be_in,
  input  logic [ADDR_W-1:0] data_addr_in,
  input  logic [DATA_W-1:0] data_data_in,
  output logic              data_ack_out,
  output logic [DATA_W-1:0] data_data_out,

  output logic              mem_cyc_out,
  output logic              mem_stb_out,
  output logic              mem_we_out,
  output logic [3:0]        mem_sel_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_ack_in,
  input  logic              mem_stall_in,
  input  logic [DATA_W-1:0] mem_data_in
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_REQ  = 3'd1,
    D_WAIT = 3'd2,
    I_REQ  = 3'd3,
    I_WAIT = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic                mem_cyc_reg, mem_cyc_next;
  logic                mem_stb_reg, mem_stb_next;
  logic                mem_we_reg, mem_we_next;
  logic [3:0]          mem_sel_reg, mem_sel_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_data_reg, mem_data_next;
  logic                inst_ack_reg, inst_ack_next;
  logic [DATA_W-1:0]   inst_data_reg, inst_data_next;
  logic                data_ack_reg, data_ack_next;
  logic [DATA_W-1:0]   data_data_reg, data_data_next;
  // Sticky flag: CPU abandoned the fetch currently in flight.
  logic                inst_abort_reg, inst_abort_next;
`ifdef CPU_ARB_RR_EN
  // 1 when the most recent completed transaction belonged to the data port.
  logic                last_data_reg, last_data_next;
`endif

  logic                data_req;
  logic                inst_req;
  logic                inst_first;
  logic                grant_data;
  logic                grant_inst;
  logic                inst_done_ack;

  // ---------------------------------------------------------------------------
  // Size to byte-lane conversion for the data port
  // ---------------------------------------------------------------------------
  logic [3:0]          byte_sel;
  logic [3:0]          store_sel;
  logic [DATA_W-1:0]   store_data;

  // One-hot byte select from the low address bits.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_sel
      assign byte_sel[gi] = (data_addr_in[1:0] == 2'(gi));
    end
  endgenerate

  always_comb begin
    store_sel  = 4'hF;
    store_data = data_data_in;
    case (data_be_in)
      2'b00: begin
        store_sel  = byte_sel;
        store_data = {4{data_data_in[7:0]}};
      end
      2'b01: begin
        store_sel  = data_addr_in[1] ? 4'b1100 : 4'b0011;
        store_data = {2{data_data_in[15:0]}};
      end
      default: begin
        store_sel  = 4'hF;
        store_data = data_data_in;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request qualification and arbitration
  // ---------------------------------------------------------------------------
  // A port whose ack is high this cycle is still holding its strobe while the
  // CPU reacts; ignore it for that one cycle so the access is not re-issued.
  assign data_req = data_stb_in & ~data_ack_reg;
  assign inst_req = inst_cyc_in & inst_stb_in & ~inst_ack_reg;

`ifdef CPU_ARB_RR_EN
  assign inst_first = last_data_reg;
`else
  assign inst_first = 1'b0;
`endif

  assign grant_data = data_req & ~(inst_req & inst_first);
  assign grant_inst = inst_req & ~grant_data;

  assign inst_stall_out = ~((state_reg == IDLE) & grant_inst);

  // The fetch is acked only if the CPU kept its cycle up throughout.
  assign inst_done_ack = ~inst_abort_reg & inst_cyc_in;

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    mem_cyc_next    = mem_cyc_reg;
    mem_stb_next    = mem_stb_reg;
    mem_we_next     = mem_we_reg;
    mem_sel_next    = mem_sel_reg;
    mem_addr_next   = mem_addr_reg;
    mem_data_next   = mem_data_reg;
    inst_ack_next   = 1'b0;
    inst_data_next  = inst_data_reg;
    data_ack_next   = 1'b0;
    data_data_next  = data_data_reg;
    inst_abort_next = inst_abort_reg;
`ifdef CPU_ARB_RR_EN
    last_data_next  = last_data_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (grant_data) begin
          mem_cyc_next  = 1'b1;
          mem_stb_next  = 1'b1;
          mem_we_next   = data_we_in;
          mem_sel_next  = store_sel;
          mem_addr_next = {data_addr_in[ADDR_W-1:2], 2'b00};
          mem_data_next = store_data;
          state_next    = D_REQ;
        end else if (grant_inst) begin
          mem_cyc_next    = 1'b1;
          mem_stb_next    = 1'b1;
          mem_we_next     = 1'b0;
          mem_sel_next    = 4'hF;
          mem_addr_next   = {inst_addr_in[ADDR_W-1:2], 2'b00};
          mem_data_next   = '0;
          inst_abort_next = 1'b0;
          state_next      = I_REQ;
        end
      end

      D_REQ, D_WAIT: begin
        // Strobe is accepted on the first edge without stall; the slave may
        // ack on that same edge.
        if (state_reg == D_REQ && !mem_stall_in) begin
          mem_stb_next = 1'b0;
          state_next   = D_WAIT;
        end
        if ((state_reg == D_WAIT || !mem_stall_in) && mem_ack_in) begin
          mem_cyc_next   = 1'b0;
          mem_stb_next   = 1'b0;
          data_ack_next  = 1'b1;
          data_data_next = mem_data_in;
          state_next     = IDLE;
`ifdef CPU_ARB_RR_EN
          last_data_next = 1'b1;
`endif
        end
      end

      I_REQ, I_WAIT: begin
        inst_abort_next = inst_abort_reg | ~inst_cyc_in;
        if (state_reg == I_REQ && !mem_stall_in) begin
          mem_stb_next = 1'b0;
          state_next   = I_WAIT;
        end
        if ((state_reg == I_WAIT || !mem_stall_in) && mem_ack_in) begin
          mem_cyc_next    = 1'b0;
          mem_stb_next    = 1'b0;
          inst_ack_next   = inst_done_ack;
          inst_data_next  = mem_data_in;
          inst_abort_next = 1'b0;
          state_next      = IDLE;
`ifdef CPU_ARB_RR_EN
          last_data_next  = 1'b0;
`endif
        end
      end

      default: begin
        mem_cyc_next = 1'b0;
        mem_stb_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_reg      <= IDLE;
      mem_cyc_reg    <= 1'b0;
      mem_stb_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_sel_reg    <= '0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
      inst_ack_reg   <= 1'b0;
      inst_data_reg  <= '0;
      data_ack_reg   <= 1'b0;
      data_data_reg  <= '0;
      inst_abort_reg <= 1'b0;
`ifdef CPU_ARB_RR_EN
      last_data_reg  <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      mem_cyc_reg    <= mem_cyc_next;
      mem_stb_reg    <= mem_stb_next;
      mem_we_reg     <= mem_we_next;
      mem_sel_reg    <= mem_sel_next;
      mem_addr_reg   <= mem_addr_next;
      mem_data_reg   <= mem_data_next;
      inst_ack_reg   <= inst_ack_next;
      inst_data_reg  <= inst_data_next;
      data_ack_reg   <= data_ack_next;
      data_data_reg  <= data_data_next;
      inst_abort_reg <= inst_abort_next;
`ifdef CPU_ARB_RR_EN
      last_data_reg  <= last_data_next;
`endif
    end
  end

  assign mem_cyc_out   = mem_cyc_reg;
  assign mem_stb_out   = mem_stb_reg;
  assign mem_we_out    = mem_we_reg;
  assign mem_sel_out   = mem_sel_reg;
  assign mem_addr_out  = mem_addr_reg;
  assign mem_data_out  = mem_data_reg;
  assign inst_ack_out  = inst_ack_reg;
  assign inst_data_out = inst_data_reg;
  assign data_ack_out  = data_ack_reg;
  assign data_data_out = data_data_reg;

endmodule

// File: tb/tb_cpu_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_cpu_mem_arb
//
// Directed bench for cpu_mem_arb. The memory slave is driven by hand, one
// step at a time; every expected value is written out in the sequence.
// Inputs change #1 after a rising edge and outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_cpu_mem_arb;

  logic        sys_clk;
  logic        sys_rst;
  logic        inst_cyc_in;
  logic        inst_stb_in;
  logic [31:0] inst_addr_in;
  logic        inst_ack_out;
  logic [31:0] inst_data_out;
  logic        inst_stall_out;
  logic        data_stb_in;
  logic        data_we_in;
  logic [1:0]  data_be_in;
  logic [31:0] data_addr_in;
  logic [31:0] data_data_in;
  logic        data_ack_out;
  logic [31:0] data_data_out;
  logic        mem_cyc_out;
  logic        mem_stb_out;
  logic        mem_we_out;
  logic [3:0]  mem_sel_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic        mem_ack_in;
  logic        mem_stall_in;
  logic [31:0] mem_data_in;

  int checks   = 0;
  int failures = 0;

  cpu_mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .inst_cyc_in    (inst_cyc_in),
    .inst_stb_in    (inst_stb_in),
    .inst_addr_in   (inst_addr_in),
    .inst_ack_out   (inst_ack_out),
    .inst_data_out  (inst_data_out),
    .inst_stall_out (inst_stall_out),
    .data_stb_in    (data_stb_in),
    .data_we_in     (data_we_in),
    .data_be_in     (data_be_in),
    .data_addr_in   (data_addr_in),
    .data_data_in   (data_data_in),
    .data_ack_out   (data_ack_out),
    .data_data_out  (data_data_out),
    .mem_cyc_out    (mem_cyc_out),
    .mem_stb_out    (mem_stb_out),
    .mem_we_out     (mem_we_out),
    .mem_sel_out    (mem_sel_out),
    .mem_addr_out   (mem_addr_out),
    .mem_data_out   (mem_data_out),
    .mem_ack_in     (mem_ack_in),
    .mem_stall_in   (mem_stall_in),
    .mem_data_in    (mem_data_in)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst      = 1'b0;
    inst_cyc_in  = 1'b0;
    inst_stb_in  = 1'b0;
    inst_addr_in = '0;
    data_stb_in  = 1'b0;
    data_we_in   = 1'b0;
    data_be_in   = 2'b00;
    data_addr_in = '0;
    data_data_in = '0;
    mem_ack_in   = 1'b0;
    mem_stall_in = 1'b0;
    mem_data_in  = '0;

    // ---- Reset state ----
    tick();
    tick();
    chk("rst_cyc", mem_cyc_out, 0);
    chk("rst_stb", mem_stb_out, 0);
    chk("rst_iack", inst_ack_out, 0);
    chk("rst_dack", data_ack_out, 0);
    chk("rst_addr", mem_addr_out, 0);
    chk("rst_istall", inst_stall_out, 1);
    sys_rst = 1'b1;
    tick();

    // ---- Stray mem_ack in IDLE is ignored ----
    mem_ack_in = 1'b1;
    tick();
    mem_ack_in = 1'b0;
    chk("idle_ack_i", inst_ack_out, 0);
    chk("idle_ack_d", data_ack_out, 0);
    chk("idle_ack_cyc", mem_cyc_out, 0);

    // ---- Single instruction fetch at 0x100 ----
    inst_cyc_in  = 1'b1;
    inst_stb_in  = 1'b1;
    inst_addr_in = 32'h100;
    #1 chk("if_stall0", inst_stall_out, 0);
    tick();                               // edge N: request sampled
    chk("if_stb", mem_stb_out, 1);
    chk("if_cyc", mem_cyc_out, 1);
    chk("if_we", mem_we_out, 0);
    chk("if_sel", mem_sel_out, 4'hF);
    chk("if_addr", mem_addr_out, 32'h100);
    chk("if_stall1", inst_stall_out, 1);
    inst_stb_in = 1'b0;
    tick();                               // edge N+1: strobe accepted
    chk("if_stb_drop", mem_stb_out, 0);
    chk("if_cyc_hold", mem_cyc_out, 1);
    chk("if_noack", inst_ack_out, 0);
    mem_ack_in  = 1'b1;
    mem_data_in = 32'h0050_0093;
    tick();                               // edge N+2: ack sampled
    mem_ack_in = 1'b0;
    chk("if_ack", inst_ack_out, 1);
    chk("if_data", inst_data_out, 32'h0050_0093);
    chk("if_cyc_end", mem_cyc_out, 0);
    inst_cyc_in = 1'b0;
    tick();
    chk("if_ack_pulse", inst_ack_out, 0);

    // ---- Simultaneous inst 0x40 and data load 0x80; data first ----
    inst_cyc_in  = 1'b1;
    inst_stb_in  = 1'b1;
    inst_addr_in = 32'h40;
    data_stb_in  = 1'b1;
    data_we_in   = 1'b0;
    data_be_in   = 2'b10;
    data_addr_in = 32'h80;
    #1 chk("arb_istall", inst_stall_out, 1);
    tick();
    chk("arb_d_addr", mem_addr_out, 32'h80);
    chk("arb_d_we", mem_we_out, 0);
    chk("arb_d_sel", mem_sel_out, 4'hF);
    tick();
    mem_ack_in  = 1'b1;
    mem_data_in = 32'h1122_3344;
    tick();
    mem_ack_in = 1'b0;
    chk("arb_d_ack", data_ack_out, 1);
    chk("arb_d_data", data_data_out, 32'h1122_3344);
    // Second data request already waiting; instruction must go next.
    data_addr_in = 32'h84;
    #1 chk("arb_istall_go", inst_stall_out, 0);
    tick();
    chk("arb_i_addr", mem_addr_out, 32'h40);
    chk("arb_i_we", mem_we_out, 0);
    chk("arb_d_ack_pulse", data_ack_out, 0);
    inst_stb_in = 1'b0;
    tick();
    mem_ack_in  = 1'b1;
    mem_data_in = 32'hCAFE_F00D;
    tick();
    mem_ack_in = 1'b0;
    chk("arb_i_ack", inst_ack_out, 1);
    chk("arb_i_data", inst_data_out, 32'hCAFE_F00D);
    inst_cyc_in = 1'b0;
    tick();
    chk("arb_d2_addr", mem_addr_out, 32'h84);
    chk("arb_d2_stb", mem_stb_out, 1);
    tick();
    mem_ack_in  = 1'b1;
    mem_data_in = 32'h5566_7788;
    tick();
    mem_ack_in = 1'b0;
    chk("arb_d2_ack", data_ack_out, 1);
    chk("arb_d2_data", data_data_out, 32'h5566_7788);
    tick();
    data_stb_in = 1'b0;

    // ---- Byte store 0xAB to 0x203 ----
    data_stb_in  = 1'b1;
    data_we_in   = 1'b1;
    data_be_in   = 2'b00;
    data_addr_in = 32'h203;
    data_data_in = 32'h0000_00AB;
    tick();
    chk("sb_addr", mem_addr_out, 32'h200);
    chk("sb_sel", mem_sel_out, 4'b1000);
    chk("sb_data", mem_data_out, 32'hABAB_ABAB);
    chk("sb_we", mem_we_out, 1);
    tick();
    mem_ack_in = 1'b1;
    tick();
    mem_ack_in = 1'b0;
    chk("sb_ack", data_ack_out, 1);
    tick();                               // stb still high during ack cycle
    chk("sb_no_reissue", mem_cyc_out, 0);
    chk("sb_ack_pulse", data_ack_out, 0);
    data_stb_in = 1'b0;

    // ---- Half store 0x1234 to 0x206 with 4 stall cycles ----
    data_stb_in  = 1'b1;
    data_be_in   = 2'b01;
    data_addr_in = 32'h206;
    data_data_in = 32'h0000_1234;
    mem_stall_in = 1'b1;
    tick();
    chk("sh_sel", mem_sel_out, 4'b1100);
    chk("sh_data", mem_data_out, 32'h1234_1234);
    chk("sh_addr", mem_addr_out, 32'h204);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_stall_in = 1'b0;
      tick();
      if (i < 3) begin
        chk("sh_stall_stb", mem_stb_out, 1);
        chk("sh_stall_addr", mem_addr_out, 32'h204);
        chk("sh_stall_sel", mem_sel_out, 4'b1100);
      end
    end
    chk("sh_accept_stb", mem_stb_out, 0);
    chk("sh_accept_cyc", mem_cyc_out, 1);
    mem_ack_in = 1'b1;
    tick();
    mem_ack_in = 1'b0;
    chk("sh_ack", data_ack_out, 1);
    tick();
    chk("sh_ack_pulse", data_ack_out, 0);
    chk("sh_no_reissue", mem_cyc_out, 0);
    data_stb_in = 1'b0;

    // ---- Word store to 0x12 with ack on the accept edge ----
    data_stb_in  = 1'b1;
    data_be_in   = 2'b11;
    data_addr_in = 32'h12;
    data_data_in = 32'hDEAD_BEEF;
    tick();
    chk("sw_sel", mem_sel_out, 4'hF);
    chk("sw_addr", mem_addr_out, 32'h10);
    chk("sw_data", mem_data_out, 32'hDEAD_BEEF);
    mem_ack_in = 1'b1;
    tick();
    mem_ack_in = 1'b0;
    chk("sw_fast_ack", data_ack_out, 1);
    chk("sw_fast_cyc", mem_cyc_out, 0);
    tick();
    data_stb_in = 1'b0;
    chk("sw_ack_pulse", data_ack_out, 0);

    // ---- Instruction abort in I_WAIT ----
    inst_cyc_in  = 1'b1;
    inst_stb_in  = 1'b1;
    inst_addr_in = 32'h300;
    tick();
    chk("ab_addr", mem_addr_out, 32'h300);
    inst_stb_in = 1'b0;
    tick();
    inst_cyc_in = 1'b0;
    tick();
    chk("ab_cyc_hold", mem_cyc_out, 1);
    mem_ack_in  = 1'b1;
    mem_data_in = 32'h1357_9BDF;
    tick();
    mem_ack_in = 1'b0;
    chk("ab_cyc_end", mem_cyc_out, 0);
    chk("ab_no_ack", inst_ack_out, 0);
    inst_cyc_in  = 1'b1;
    inst_stb_in  = 1'b1;
    inst_addr_in = 32'h304;
    #1 chk("ab_next_stall", inst_stall_out, 0);
    tick();
    chk("ab_next_addr", mem_addr_out, 32'h304);
    chk("ab_next_stb", mem_stb_out, 1);
    inst_stb_in = 1'b0;
    tick();
    mem_ack_in  = 1'b1;
    mem_data_in = 32'h2468_ACE0;
    tick();
    mem_ack_in = 1'b0;
    chk("ab_next_ack", inst_ack_out, 1);
    chk("ab_next_data", inst_data_out, 32'h2468_ACE0);
    inst_cyc_in = 1'b0;
    tick();

    // ---- Reset asserted mid D_WAIT ----
    data_stb_in  = 1'b1;
    data_we_in   = 1'b0;
    data_be_in   = 2'b10;
    data_addr_in = 32'h400;
    tick();
    tick();
    chk("rs_wait_cyc", mem_cyc_out, 1);
    #2 sys_rst = 1'b0;
    #1;
    chk("rs_async_cyc", mem_cyc_out, 0);
    chk("rs_async_stb", mem_stb_out, 0);
    chk("rs_async_addr", mem_addr_out, 0);
    data_stb_in = 1'b0;
    tick();
    sys_rst = 1'b1;
    mem_ack_in = 1'b1;                    // late slave ack must be ignored
    tick();
    mem_ack_in = 1'b0;
    chk("rs_post_cyc", mem_cyc_out, 0);
    chk("rs_post_dack", data_ack_out, 0);
    chk("rs_post_iack", inst_ack_out, 0);
    tick();
    chk("rs_idle_cyc", mem_cyc_out, 0);
    chk("rs_idle_stall", inst_stall_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arb.md
Name: cpu_mem_arb

Overview:
- Arbiter that sits directly downstream of the CPU top.
- Merges the CPU instruction port (cyc/stb/addr/ack/data/stall) and the CPU data port (stb/we/be/addr/data/ack) onto a single pipelined Wishbone master toward unified memory.
- One outstanding memory transaction at a time.
- Converts the CPU 2-bit access size into byte selects and write-data lane replication.

Parameters:
- ADDR_W, 32, address width of both CPU ports and the memory port.
- DATA_W, 32, data width; fixed at 32 (sel is DATA_W/8 = 4 bits).

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  asynchronous active-low reset
- inst_cyc_in  in  1  CPU instruction cycle
- inst_stb_in  in  1  CPU instruction strobe
- inst_addr_in  in  ADDR_W  instruction address
- inst_ack_out  out  1  instruction ack, one-cycle pulse
- inst_data_out  out  DATA_W  instruction word, valid with ack
- inst_stall_out  out  1  instruction strobe not accepted this cycle
- data_stb_in  in  1  CPU data strobe, held until ack
- data_we_in  in  1  1 = store
- data_be_in  in  2  size: 00 byte, 01 half, 10/11 word
- data_addr_in  in  ADDR_W  byte address
- data_data_in  in  DATA_W  store data, right-aligned
- data_ack_out  out  1  data ack, one-cycle pulse
- data_data_out  out  DATA_W  raw load word, valid with ack
- mem_cyc_out  out  1  memory cycle
- mem_stb_out  out  1  memory strobe
- mem_we_out  out  1  memory write enable
- mem_sel_out  out  4  byte selects
- mem_addr_out  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_data_out  out  DATA_W  write data
- mem_ack_in  in  1  memory ack
- mem_stall_in  in  1  memory stall
- mem_data_in  in  DATA_W  memory read data

Behaviour:
- Reset (sys_rst=0, async):
  - State goes to IDLE.
  - All mem_* outputs, inst_ack_out, data_ack_out, inst_data_out and data_data_out go to 0 immediately.
  - Grant history is cleared.
- State machine: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT. All outputs are registered except inst_stall_out.
- IDLE:
  - A request is masked for one cycle if that port's ack is high this cycle; this prevents re-issue while the CPU drops stb.
  - data_stb_in unmasked → latch fields, drive mem_cyc=mem_stb=1 → D_REQ.
  - Else inst_cyc_in & inst_stb_in unmasked → I_REQ with mem_we=0, sel=4'hF.
  - Fixed priority: data wins when both request.
- inst_stall_out = 0 only in IDLE when the instruction request would be granted; 1 otherwise.
- X_REQ:
  - mem_stb held while mem_stall_in=1; fields stable.
  - Edge with mem_stall_in=0: drop stb, keep cyc.
  - If mem_ack_in is also 1 on that edge → complete; otherwise → X_WAIT.
- X_WAIT: on mem_ack_in → complete.
- Completion, at the same edge:
  - mem_cyc goes to 0; state returns to IDLE.
  - Port ack pulses high for one cycle with mem_data_in registered into the port data output.
- Minimum latency with a zero-wait slave (ack one cycle after stb accepted): request sampled at edge N, mem_stb high after N, ack sampled at N+2, port ack high after N+2. That is 3 edges.
- Instruction abort: if inst_cyc_in drops while in I_REQ/I_WAIT, the memory transaction still completes, but inst_ack_out is suppressed.
- Data size to select lanes, using a = data_addr_in[1:0]:
  - byte: sel = 4'b0001<<a; wdata = {4{d[7:0]}}.
  - half: sel = a[1] ? 4'b1100 : 4'b0011; wdata = {2{d[15:0]}}.
  - word: sel = 4'hF; wdata = d.
- Misaligned half/word: the low address bits are ignored by the word-aligned mem_addr_out.
- Load data is returned unshifted; the CPU performs extraction and sign extension.
- mem_ack_in outside X_REQ/X_WAIT is ignored.

Optional Feature:
- Macro CPU_ARB_RR_EN.
- Defined: round-robin. After a completed data transaction, if both ports request in IDLE, the instruction port wins. After an instruction transaction, data wins.
- Undefined: fixed data priority; instruction requests can starve under back-to-back data traffic.

Test Plan:
- Single instruction fetch, addr 0x100, stall=0, slave acks 1 cycle after stb accepted, data 0x00500093 → mem_sel=F, mem_we=0, inst_ack_out 1-cycle pulse with 0x00500093, 3 edges after request.
- Byte store to 0x203 with data 0x000000AB → mem_addr=0x200, sel=4'b1000, mem_data=0xABABABAB, we=1, data_ack_out single pulse, no re-issue while stb still high in the ack cycle.
- Simultaneous inst request at 0x40 and data load at 0x80 → data granted first (inst_stall_out=1), then inst. With CPU_ARB_RR_EN and a second data request pending, inst precedes the second data access.
- mem_stall_in=1 for 4 cycles during D_REQ → mem_stb/addr/sel stable for all 4 cycles, accepted on the 5th, ack still a single pulse.
- inst_cyc_in dropped in I_WAIT → memory cycle completes, inst_ack_out stays 0, next request granted from IDLE.
- sys_rst=0 asserted mid-D_WAIT → mem_cyc_out/mem_stb_out drop before the next clock edge. After release: IDLE, no spurious acks.
